vga_timing_pipe: RTL and testbench

Parametrised VGA timing generator and pixel output stage for the DE1-SoC ADV7123 DAC path. It sits between the frame-buffer/renderer logic and the VGA pins. It issues per-pixel requests with (x, y) coordinates ahead of display time and absorbs a configurable read latency. It delays sync and blanking to match that latency, then expands narrow colour input to 8 bits per channel. It supports any timing mode through parameters and runs from a faster system clock through a pixel-enable strobe.

---
 rtl/vga_timing_pipe_if.sv | 25 ++
 rtl/vga_timing_pipe.sv | 140 ++++++++++++++
 tb/tb_vga_timing_pipe.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pipe_if.sv
// Pixel request / colour return channel between the VGA timing pipe and the renderer.
// The timing pipe is the master: it issues coordinates and receives colour.
interface vga_timing_pipe_if #(
  parameter int unsigned COLOR_W = 5
);
  logic               req;
  logic [9:0]         x;
  logic [9:0]         y;
  logic               frame_start;
  logic               line_start;
  logic               vblank;
  logic [COLOR_W-1:0] red_in;
  logic [COLOR_W-1:0] green_in;
  logic [COLOR_W-1:0] blue_in;

  modport master (
    output req, x, y, frame_start, line_start, vblank,
    input  red_in, green_in, blue_in
  );

  modport slave (
    input  req, x, y, frame_start, line_start, vblank,
    output red_in, green_in, blue_in
  );
endinterface

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing generator with latency-matched sync/blank and colour expansion
// to 8 bits per channel for the ADV7123 DAC.
module vga_timing_pipe #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          HSYNC_POL   = 1'b0,
  parameter bit          VSYNC_POL   = 1'b0,
  parameter int unsigned COLOR_W     = 5,
  parameter int unsigned PIX_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_en,
  vga_timing_pipe_if.master     pix,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic                  vga_blank_n,
  output logic                  vga_sync_n,
  output logic [7:0]            vga_red,
  output logic [7:0]            vga_green,
  output logic [7:0]            vga_blue
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END  = H_ACTIVE + H_FRONT + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END  = V_ACTIVE + V_FRONT + V_SYNC;
  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

  // Decode vector bit positions carried through the delay line
  localparam int unsigned D_ACT = 2;
  localparam int unsigned D_HS  = 1;
  localparam int unsigned D_VS  = 0;

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           act0;
  logic           hs0;
  logic           vs0;
  logic           origin;
  logic [2:0]     dec0;
  logic [2:0]     dec_d;
  logic [7:0]     red_x;
  logic [7:0]     green_x;
  logic [7:0]     blue_x;

  // Raster counters
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) v_cnt <= '0;
        else                 v_cnt <= v_cnt + V_W'(1);
      end else begin
        h_cnt <= h_cnt + H_W'(1);
      end
    end
  end

  // Stage-0 region decode
  always_comb begin
    act0   = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    hs0    = (32'(h_cnt) >= HS_BEG) && (32'(h_cnt) < HS_END);
    vs0    = (32'(v_cnt) >= VS_BEG) && (32'(v_cnt) < VS_END);
    origin = (h_cnt == '0);
    dec0   = '0;
    dec0[D_ACT] = act0;
    dec0[D_HS]  = hs0;
    dec0[D_VS]  = vs0;
  end

  // Pulses are gated by reset so nothing fires while the counters are being forced
  assign pix.req         = act0;
  assign pix.x           = act0 ? 10'(h_cnt) : 10'd0;
  assign pix.y           = act0 ? 10'(v_cnt) : 10'd0;
  assign pix.line_start  = pix_en & ~reset & act0 & origin;
  assign pix.frame_start = pix_en & ~reset & act0 & origin & (v_cnt == '0);
  assign pix.vblank      = (32'(v_cnt) >= V_ACTIVE);

  // Delay line matching the renderer read latency
  if (PIX_LATENCY == 0) begin : g_no_dly
    assign dec_d = dec0;
  end else begin : g_dly
    logic [2:0] dly [PIX_LATENCY];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned i = 0; i < PIX_LATENCY; i++) dly[i] <= '0;
      end else if (pix_en) begin
        dly[0] <= dec0;
        for (int unsigned i = 1; i < PIX_LATENCY; i++) dly[i] <= dly[i-1];
      end
    end

    assign dec_d = dly[PIX_LATENCY-1];
  end

  // MSB-replication expansion: bit 7-i takes input bit (MSB - i mod width)
  for (genvar i = 0; i < 8; i++) begin : g_exp
    assign red_x[7-i]   = pix.red_in[COLOR_W-1-(i % COLOR_W)];
    assign green_x[7-i] = pix.green_in[COLOR_W-1-(i % COLOR_W)];
    assign blue_x[7-i]  = pix.blue_in[COLOR_W-1-(i % COLOR_W)];
  end

  // Pin register
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_blank_n <= 1'b0;
      vga_hsync   <= ~HSYNC_POL;
      vga_vsync   <= ~VSYNC_POL;
      vga_red     <= '0;
      vga_green   <= '0;
      vga_blue    <= '0;
    end else if (pix_en) begin
      vga_blank_n <= dec_d[D_ACT];
      vga_hsync   <= dec_d[D_HS] ? HSYNC_POL : ~HSYNC_POL;
      vga_vsync   <= dec_d[D_VS] ? VSYNC_POL : ~VSYNC_POL;
      vga_red     <= dec_d[D_ACT] ? red_x   : 8'h00;
      vga_green   <= dec_d[D_ACT] ? green_x : 8'h00;
      vga_blue    <= dec_d[D_ACT] ? blue_x  : 8'h00;
    end
  end

  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Directed bench: a default 640x480 instance (L=1, COLOR_W=5) and a small-mode instance
// (14x7 raster, L=3, COLOR_W=8, active-high hsync) sharing one clock.
module tb_vga_timing_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- instance A: default timing ----------------
  logic       a_reset = 1'b1;
  logic       a_pix_en = 1'b1;
  logic       a_red_echo = 1'b1;
  logic [4:0] a_red_drive = 5'h00;
  logic [4:0] a_red_q;
  logic       a_hsync, a_vsync, a_blank_n, a_sync_n;
  logic [7:0] a_red, a_green, a_blue;

  vga_timing_pipe_if #(.COLOR_W(5)) a_if ();

  // One-tick renderer: returns x[4:0] as red one pixel tick after the request
  always @(posedge clk) if (a_pix_en) a_red_q <= a_if.x[4:0];
  assign a_if.red_in   = a_red_echo ? a_red_q : a_red_drive;
  assign a_if.green_in = 5'h10;
  assign a_if.blue_in  = 5'h00;

  vga_timing_pipe u_a (
    .clk         (clk),
    .reset       (a_reset),
    .pix_en      (a_pix_en),
    .pix         (a_if),
    .vga_hsync   (a_hsync),
    .vga_vsync   (a_vsync),
    .vga_blank_n (a_blank_n),
    .vga_sync_n  (a_sync_n),
    .vga_red     (a_red),
    .vga_green   (a_green),
    .vga_blue    (a_blue)
  );

  // ---------------- instance B: small mode ----------------
  logic       b_reset = 1'b1;
  logic       b_pix_en = 1'b1;
  logic       b_hsync, b_vsync, b_blank_n, b_sync_n;
  logic [7:0] b_red, b_green, b_blue;

  vga_timing_pipe_if #(.COLOR_W(8)) b_if ();

  assign b_if.red_in   = 8'hA5;
  assign b_if.green_in = 8'h00;
  assign b_if.blue_in  = 8'h3C;

  vga_timing_pipe #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0),
    .COLOR_W(8), .PIX_LATENCY(3)
  ) u_b (
    .clk         (clk),
    .reset       (b_reset),
    .pix_en      (b_pix_en),
    .pix         (b_if),
    .vga_hsync   (b_hsync),
    .vga_vsync   (b_vsync),
    .vga_blank_n (b_blank_n),
    .vga_sync_n  (b_sync_n),
    .vga_red     (b_red),
    .vga_green   (b_green),
    .vga_blue    (b_blue)
  );

  initial begin
    int en_cnt;
    int fs_n, ls_n, vb_n, hs_n, vs_n, rq_n;

    // ---- A: reset state ----
    repeat (3) tick();
    check("a_rst_hsync", a_hsync, 1);
    check("a_rst_vsync", a_vsync, 1);
    check("a_rst_blank", a_blank_n, 0);
    check("a_rst_red", a_red, 0);
    check("a_sync_n", a_sync_n, 0);
    check("a_rst_req", a_if.req, 1);
    check("a_rst_x", a_if.x, 0);
    check("a_rst_fs", a_if.frame_start, 0);
    check("a_rst_ls", a_if.line_start, 0);

    // ---- A: first line and start of second, t = edges since release ----
    a_reset = 1'b0;
    #1;
    check("a_fs_first", a_if.frame_start, 1);
    check("a_ls_first", a_if.line_start, 1);
    for (int t = 1; t <= 1100; t++) begin
      tick();
      case (t)
        1:    check("a_blank_lag", a_blank_n, 0);
        2:    begin check("a_blank_rise", a_blank_n, 1); check("a_red_x0", a_red, 8'h00); end
        18:   check("a_red_x16", a_red, 8'h84);
        33:   begin check("a_red_x31", a_red, 8'hFF); check("a_green", a_green, 8'h84); end
        300:  begin check("a_x300", a_if.x, 300); check("a_vblank0", a_if.vblank, 0); end
        641:  check("a_blank_last", a_blank_n, 1);
        642:  begin
                check("a_blank_fall", a_blank_n, 0);
                check("a_red_blank", a_red, 0);
                check("a_green_blank", a_green, 0);
                check("a_req_blank", a_if.req, 0);
              end
        657:  check("a_hs_pre", a_hsync, 1);
        658:  check("a_hs_start", a_hsync, 0);
        753:  check("a_hs_end", a_hsync, 0);
        754:  check("a_hs_post", a_hsync, 1);
        800:  begin
                check("a_ls_line1", a_if.line_start, 1);
                check("a_fs_line1", a_if.frame_start, 0);
                check("a_y_line1", a_if.y, 1);
              end
        1100: begin check("a_mid_x", a_if.x, 300); check("a_mid_y", a_if.y, 1); end
        default: ;
      endcase
    end

    // ---- A: reset mid-frame, colour forced non-zero ----
    a_red_echo  = 1'b0;
    a_red_drive = 5'h1F;
    a_reset     = 1'b1;
    tick();
    check("a_mrst_red", a_red, 0);
    check("a_mrst_blank", a_blank_n, 0);
    check("a_mrst_hsync", a_hsync, 1);
    check("a_mrst_x", a_if.x, 0);
    check("a_mrst_y", a_if.y, 0);
    check("a_mrst_fs", a_if.frame_start, 0);
    a_reset = 1'b0;
    #1;
    check("a_mrst_fs_rel", a_if.frame_start, 1);
    tick();
    check("a_no_stale_red", a_red, 0);
    check("a_no_stale_blank", a_blank_n, 0);
    tick();
    check("a_post_red", a_red, 8'hFF);
    check("a_post_blank", a_blank_n, 1);

    // ---- A: pix_en every other cycle; colour input wiggles on idle cycles ----
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    en_cnt  = 0;
    for (int i = 0; i < 12; i++) begin
      a_pix_en    = i[0];
      a_red_drive = i[0] ? 5'h1F : 5'h00;
      #1;
      if (en_cnt == 0) check("a_en_fs", a_if.frame_start, 32'(i[0]));
      tick();
      if (i[0]) en_cnt++;
      check("a_en_x", a_if.x, en_cnt);
      check("a_en_blank", a_blank_n, (en_cnt >= 2) ? 1 : 0);
      check("a_en_red", a_red, (en_cnt >= 2) ? 8'hFF : 8'h00);
    end
    a_pix_en = 1'b1;

    // ---- B: small mode, one full frame ----
    check("b_rst_hsync", b_hsync, 0);
    check("b_rst_vsync", b_vsync, 1);
    b_reset = 1'b0;
    #1;
    fs_n = 0; ls_n = 0; vb_n = 0; hs_n = 0; vs_n = 0; rq_n = 0;
    for (int t = 0; t < 98; t++) begin
      if (t > 0) tick();
      fs_n += int'(b_if.frame_start);
      ls_n += int'(b_if.line_start);
      vb_n += int'(b_if.vblank);
      hs_n += int'(b_hsync);
      vs_n += int'(!b_vsync);
      rq_n += int'(b_if.req);
      case (t)
        0:  check("b_fs_first", b_if.frame_start, 1);
        3:  check("b_blank_lag", b_blank_n, 0);
        4:  begin check("b_blank_rise", b_blank_n, 1); check("b_red", b_red, 8'hA5); end
        11: check("b_blank_last", b_blank_n, 1);
        12: begin check("b_blank_fall", b_blank_n, 0); check("b_red_blank", b_red, 0); end
        13: check("b_hs_idle", b_hsync, 0);
        14: begin
              check("b_hs_high", b_hsync, 1);
              check("b_y1", b_if.y, 1);
              check("b_ls1", b_if.line_start, 1);
            end
        16: check("b_hs_end", b_hsync, 0);
        55: check("b_vblank_lo", b_if.vblank, 0);
        56: check("b_vblank_hi", b_if.vblank, 1);
        73: check("b_vs_pre", b_vsync, 1);
        74: check("b_vs_start", b_vsync, 0);
        88: check("b_vs_post", b_vsync, 1);
        default: ;
      endcase
    end
    check("b_fs_count", fs_n, 1);
    check("b_ls_count", ls_n, 4);
    check("b_vblank_count", vb_n, 42);
    check("b_hs_count", hs_n, 12);
    check("b_vs_count", vs_n, 14);
    check("b_req_count", rq_n, 32);
    tick();
    check("b_wrap_fs", b_if.frame_start, 1);
    check("b_wrap_x", b_if.x, 0);
    check("b_wrap_y", b_if.y, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
